// File: rtl/axil_reg_if.sv
// AXI4-Lite slave that turns write/read transactions into a strobe/acknowledge
// register interface, one outstanding access per direction, each with an ack timeout.

module axil_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic [STRB_WIDTH-1:0] reg_wr_strb,
    output logic                  reg_wr_en,
    input  logic                  reg_wr_wait,
    input  logic                  reg_wr_ack,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_rd_wait,
    input  logic                  reg_rd_ack
);

    localparam int         ALIGN       = $clog2(STRB_WIDTH);
    localparam logic [7:0] TO_LOAD     = 8'(TIMEOUT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    wr_state_e             wst_q, wst_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  wen_q, wen_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  wr_accept_s;

    rd_state_e             rst_q, rst_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  ren_q, ren_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_accept_s;

    // Protection bits and the sub-word address bits carry no meaning for this register file.
    logic unused_s;
    assign unused_s = ^{s_axil_awprot, s_axil_arprot,
                        s_axil_awaddr[ALIGN-1:0], s_axil_araddr[ALIGN-1:0]};

    assign s_axil_awready = wr_accept_s;
    assign s_axil_wready  = wr_accept_s;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign reg_wr_addr    = waddr_q;
    assign reg_wr_data    = wdata_q;
    assign reg_wr_strb    = wstrb_q;
    assign reg_wr_en      = wen_q;

    assign s_axil_arready = rd_accept_s;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign reg_rd_addr    = raddr_q;
    assign reg_rd_en      = ren_q;

    // Write path next state: joint AW/W accept, ack/timeout race, B handshake.
    always_comb begin
        wst_d       = wst_q;
        wcnt_d      = wcnt_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wen_d       = wen_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        wr_accept_s = 1'b0;
        case (wst_q)
            W_IDLE: begin
                if (s_axil_awvalid && s_axil_wvalid) begin
                    wr_accept_s = 1'b1;
                    wst_d       = W_REQ;
                    wcnt_d      = TO_LOAD;
                    waddr_d     = {s_axil_awaddr[ADDR_WIDTH-1:ALIGN], {ALIGN{1'b0}}};
                    wdata_d     = s_axil_wdata;
                    wstrb_d     = s_axil_wstrb;
                    wen_d       = 1'b1;
                end else begin
                    wst_d = W_IDLE;
                end
            end
            W_REQ: begin
                // Ack beats expiry when both land in the same cycle.
                if (reg_wr_ack) begin
                    wst_d    = W_RESP;
                    wen_d    = 1'b0;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                end else if (!reg_wr_wait) begin
                    if (wcnt_q == 8'd1) begin
                        wst_d    = W_RESP;
                        wen_d    = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end else begin
                        wcnt_d = wcnt_q - 8'd1;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    wst_d    = W_IDLE;
                    bvalid_d = 1'b0;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                wst_d    = W_IDLE;
                wen_d    = 1'b0;
                bvalid_d = 1'b0;
            end
        endcase
    end

    // Write path state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wst_q    <= W_IDLE;
            wcnt_q   <= 8'd0;
            waddr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q  <= {DATA_WIDTH{1'b0}};
            wstrb_q  <= {STRB_WIDTH{1'b0}};
            wen_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
        end else begin
            wst_q    <= wst_d;
            wcnt_q   <= wcnt_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            wen_q    <= wen_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    // Read path next state: AR accept, ack/timeout race with data capture, R handshake.
    always_comb begin
        rst_d       = rst_q;
        rcnt_d      = rcnt_q;
        raddr_d     = raddr_q;
        ren_d       = ren_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        rd_accept_s = 1'b0;
        case (rst_q)
            R_IDLE: begin
                if (s_axil_arvalid) begin
                    rd_accept_s = 1'b1;
                    rst_d       = R_REQ;
                    rcnt_d      = TO_LOAD;
                    raddr_d     = {s_axil_araddr[ADDR_WIDTH-1:ALIGN], {ALIGN{1'b0}}};
                    ren_d       = 1'b1;
                end else begin
                    rst_d = R_IDLE;
                end
            end
            R_REQ: begin
                if (reg_rd_ack) begin
                    rst_d    = R_RESP;
                    ren_d    = 1'b0;
                    rvalid_d = 1'b1;
                    rresp_d  = RESP_OKAY;
                    rdata_d  = reg_rd_data;
                end else if (!reg_rd_wait) begin
                    if (rcnt_q == 8'd1) begin
                        rst_d    = R_RESP;
                        ren_d    = 1'b0;
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_SLVERR;
                        rdata_d  = {DATA_WIDTH{1'b0}};
                    end else begin
                        rcnt_d = rcnt_q - 8'd1;
                    end
                end else begin
                    rcnt_d = rcnt_q;
                end
            end
            R_RESP: begin
                if (s_axil_rready) begin
                    rst_d    = R_IDLE;
                    rvalid_d = 1'b0;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                rst_d    = R_IDLE;
                ren_d    = 1'b0;
                rvalid_d = 1'b0;
            end
        endcase
    end

    // Read path state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q    <= R_IDLE;
            rcnt_q   <= 8'd0;
            raddr_q  <= {ADDR_WIDTH{1'b0}};
            ren_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            rst_q    <= rst_d;
            rcnt_q   <= rcnt_d;
            raddr_q  <= raddr_d;
            ren_q    <= ren_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axil_reg_if.sv
// Self-checking bench for axil_reg_if: directed scenarios plus randomized
// concurrent traffic scored against a cycle-counting model of the ack window.

module tb_axil_reg_if;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] s_axil_awaddr = '0;
    logic [2:0]    s_axil_awprot = '0;
    logic          s_axil_awvalid = 1'b0;
    logic          s_axil_awready;
    logic [DW-1:0] s_axil_wdata = '0;
    logic [SW-1:0] s_axil_wstrb = '0;
    logic          s_axil_wvalid = 1'b0;
    logic          s_axil_wready;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bvalid;
    logic          s_axil_bready = 1'b0;
    logic [AW-1:0] s_axil_araddr = '0;
    logic [2:0]    s_axil_arprot = '0;
    logic          s_axil_arvalid = 1'b0;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready = 1'b0;
    logic [AW-1:0] reg_wr_addr;
    logic [DW-1:0] reg_wr_data;
    logic [SW-1:0] reg_wr_strb;
    logic          reg_wr_en;
    logic          reg_wr_wait = 1'b0;
    logic          reg_wr_ack = 1'b0;
    logic [AW-1:0] reg_rd_addr;
    logic          reg_rd_en;
    logic [DW-1:0] reg_rd_data = '0;
    logic          reg_rd_wait = 1'b0;
    logic          reg_rd_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axil_reg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
        .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
        .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
        .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack)
    );

    // Reference: walk the request cycles after accept. The first wait_n cycles are
    // paused, every other non-ack cycle spends one unit of a TO budget.
    task automatic model(input int ack_k, input int wait_n,
                         output int en, output int lat, output logic [1:0] resp);
        int budget;
        budget = TO;
        en     = -1;
        resp   = 2'b11;
        for (int k = 1; k <= 1000; k++) begin
            if (k == ack_k) begin
                en = k; resp = 2'b00; break;
            end
            if (k > wait_n) begin
                budget = budget - 1;
                if (budget == 0) begin
                    en = k; resp = 2'b10; break;
                end
            end
        end
        lat = en + 1;
    endtask

    // Runs one write; cycle k=1 is the first cycle after the accept edge.
    task automatic wr_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int ack_k, input int wait_n,
                          input int bp_n, output int en_cnt, output int lat,
                          output logic [1:0] resp, output logic [AW-1:0] a_seen,
                          output logic [DW-1:0] d_seen, output logic [SW-1:0] s_seen,
                          output bit acc_ok, output bit bp_ok, output bit b_clear);
        @(posedge clk); #1;
        s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
        s_axil_awprot = 3'($urandom); s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        #1 acc_ok = (s_axil_awready === 1'b1) && (s_axil_wready === 1'b1);
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        en_cnt = 0; lat = -1; a_seen = '0; d_seen = '0; s_seen = '0;
        for (int k = 1; k <= 300; k++) begin
            if (s_axil_bvalid === 1'b1) begin
                lat = k; break;
            end
            if (reg_wr_en === 1'b1) begin
                if (en_cnt == 0) begin
                    a_seen = reg_wr_addr; d_seen = reg_wr_data; s_seen = reg_wr_strb;
                end
                en_cnt++;
            end
            reg_wr_ack  = (k == ack_k);
            reg_wr_wait = (k <= wait_n);
            @(posedge clk); #1;
        end
        reg_wr_ack = 1'b0; reg_wr_wait = 1'b0;
        resp  = s_axil_bresp;
        bp_ok = 1'b1;
        if (bp_n > 0) begin
            s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
            for (int i = 0; i < bp_n; i++) begin
                #1;
                if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== resp || s_axil_awready !== 1'b0)
                    bp_ok = 1'b0;
                @(posedge clk); #1;
            end
            s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        end
        s_axil_bready = 1'b1;
        @(posedge clk); #1;
        s_axil_bready = 1'b0;
        b_clear = (s_axil_bvalid === 1'b0);
    endtask

    // Runs one read; reg_rd_data carries noise on every cycle except the ack cycle.
    task automatic rd_txn(input logic [AW-1:0] addr, input logic [DW-1:0] val,
                          input int ack_k, input int wait_n, output int en_cnt,
                          output int lat, output logic [1:0] resp, output logic [DW-1:0] rdat,
                          output logic [AW-1:0] a_seen, output bit acc_ok);
        @(posedge clk); #1;
        s_axil_araddr = addr; s_axil_arprot = 3'($urandom); s_axil_arvalid = 1'b1;
        #1 acc_ok = (s_axil_arready === 1'b1);
        @(posedge clk); #1;
        s_axil_arvalid = 1'b0;
        en_cnt = 0; lat = -1; a_seen = '0;
        for (int k = 1; k <= 300; k++) begin
            if (s_axil_rvalid === 1'b1) begin
                lat = k; break;
            end
            if (reg_rd_en === 1'b1) begin
                if (en_cnt == 0) a_seen = reg_rd_addr;
                en_cnt++;
            end
            reg_rd_ack  = (k == ack_k);
            reg_rd_wait = (k <= wait_n);
            reg_rd_data = (k == ack_k) ? val : $urandom;
            @(posedge clk); #1;
        end
        reg_rd_ack = 1'b0; reg_rd_wait = 1'b0;
        resp = s_axil_rresp;
        rdat = s_axil_rdata;
        s_axil_rready = 1'b1;
        @(posedge clk); #1;
        s_axil_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
             reg_wr_en, reg_rd_en} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 0", {s_axil_awready, s_axil_wready,
                     s_axil_arready, s_axil_bvalid, s_axil_rvalid, reg_wr_en, reg_rd_en});
        end
        checks++;
        if ({s_axil_bresp, s_axil_rresp, s_axil_rdata, reg_wr_addr, reg_wr_data,
             reg_wr_strb, reg_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h waddr=%h wdata=%h raddr=%h want 0",
                     s_axil_rdata, reg_wr_addr, reg_wr_data, reg_rd_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        int en, lat; logic [1:0] resp; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
        bit acc, bp, bc;
        wr_txn(16'h0013, 32'hDEADBEEF, 4'hF, 1, 0, 0, en, lat, resp, a, d, s, acc, bp, bc);
        checks++;
        if (!acc || a !== 16'h0010 || d !== 32'hDEADBEEF || s !== 4'hF) begin
            errors++;
            $display("FAIL single_wr_req: acc=%0d addr=%h data=%h strb=%h want 1/0010/deadbeef/f",
                     acc, a, d, s);
        end
        checks++;
        if (en !== 1 || lat !== 2 || resp !== 2'b00 || !bc) begin
            errors++;
            $display("FAIL single_wr_resp: en=%0d lat=%0d bresp=%b clr=%0d want 1/2/00/1",
                     en, lat, resp, bc);
        end
    endtask

    task automatic test_aw_without_w();
        @(posedge clk); #1;
        s_axil_awaddr = 16'h0106; s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0) begin
                errors++;
                $display("FAIL aw_only_c%0d: awready=%b wready=%b want 0/0",
                         i, s_axil_awready, s_axil_wready);
            end
            @(posedge clk); #1;
        end
        s_axil_wdata = 32'hA5A5_0F0F; s_axil_wstrb = 4'h3; s_axil_wvalid = 1'b1;
        #1;
        checks++;
        if (s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1) begin
            errors++;
            $display("FAIL aw_w_join: awready=%b wready=%b want 1/1", s_axil_awready, s_axil_wready);
        end
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; reg_wr_ack = 1'b1;
        checks++;
        if (reg_wr_en !== 1'b1 || reg_wr_addr !== 16'h0104 || reg_wr_data !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL aw_w_req: en=%b addr=%h data=%h want 1/0104/a5a50f0f",
                     reg_wr_en, reg_wr_addr, reg_wr_data);
        end
        @(posedge clk); #1;
        reg_wr_ack = 1'b0;
        checks++;
        if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin
            errors++;
            $display("FAIL aw_w_resp: bvalid=%b bresp=%b want 1/00", s_axil_bvalid, s_axil_bresp);
        end
        s_axil_bready = 1'b1;
        @(posedge clk); #1;
        s_axil_bready = 1'b0;
    endtask

    task automatic test_read_wait();
        int en, lat, e_en, e_lat; logic [1:0] resp, e_resp; logic [DW-1:0] rd; logic [AW-1:0] a;
        bit acc;
        model(11, 10, e_en, e_lat, e_resp);
        rd_txn(16'h0202, 32'h12345678, 11, 10, en, lat, resp, rd, a, acc);
        checks++;
        if (!acc || en !== e_en || lat !== e_lat || resp !== 2'b00 || rd !== 32'h12345678
            || a !== 16'h0200) begin
            errors++;
            $display("FAIL read_wait: en=%0d lat=%0d rresp=%b rdata=%h addr=%h want %0d/%0d/00/12345678/0200",
                     en, lat, resp, rd, a, e_en, e_lat);
        end
    endtask

    task automatic test_timeout();
        int en, lat; logic [1:0] resp; logic [DW-1:0] rd, d; logic [AW-1:0] a; logic [SW-1:0] s;
        bit acc, bp, bc;
        rd_txn(16'h0040, 32'hFFFF_FFFF, 0, 0, en, lat, resp, rd, a, acc);
        checks++;
        if (en !== TO || lat !== TO + 1 || resp !== 2'b10 || rd !== 32'h0) begin
            errors++;
            $display("FAIL rd_timeout: en=%0d lat=%0d rresp=%b rdata=%h want %0d/%0d/10/0",
                     en, lat, resp, rd, TO, TO + 1);
        end
        wr_txn(16'h0044, 32'h0BAD_F00D, 4'h1, 0, 0, 0, en, lat, resp, a, d, s, acc, bp, bc);
        checks++;
        if (en !== TO || lat !== TO + 1 || resp !== 2'b10) begin
            errors++;
            $display("FAIL wr_timeout: en=%0d lat=%0d bresp=%b want %0d/%0d/10",
                     en, lat, resp, TO, TO + 1);
        end
    endtask

    task automatic test_ack_on_expiry();
        int en, lat; logic [1:0] resp; logic [DW-1:0] rd, d; logic [AW-1:0] a; logic [SW-1:0] s;
        bit acc, bp, bc;
        rd_txn(16'h0050, 32'h5555_AAAA, TO, 0, en, lat, resp, rd, a, acc);
        checks++;
        if (en !== TO || lat !== TO + 1 || resp !== 2'b00 || rd !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL rd_expiry_ack: en=%0d lat=%0d rresp=%b rdata=%h want %0d/%0d/00/5555aaaa",
                     en, lat, resp, rd, TO, TO + 1);
        end
        wr_txn(16'h0054, 32'h1, 4'h8, TO, 0, 0, en, lat, resp, a, d, s, acc, bp, bc);
        checks++;
        if (en !== TO || lat !== TO + 1 || resp !== 2'b00) begin
            errors++;
            $display("FAIL wr_expiry_ack: en=%0d lat=%0d bresp=%b want %0d/%0d/00",
                     en, lat, resp, TO, TO + 1);
        end
    endtask

    task automatic test_concurrent();
        int wen, wlat, ren, rlat; logic [1:0] wresp, rresp; logic [DW-1:0] rd, d;
        logic [AW-1:0] wa, ra; logic [SW-1:0] s; bit wacc, racc, bp, bc, both;
        both = 1'b0;
        fork
            wr_txn(16'h0301, 32'hCAFE_0001, 4'hC, 3, 0, 0, wen, wlat, wresp, wa, d, s, wacc, bp, bc);
            rd_txn(16'h0403, 32'hBEEF_0002, 0, 1, ren, rlat, rresp, rd, ra, racc);
            begin
                @(posedge clk); @(posedge clk); #3;
                both = (reg_wr_en === 1'b1) && (reg_rd_en === 1'b1);
            end
        join
        checks++;
        if (!both || !wacc || !racc) begin
            errors++;
            $display("FAIL concurrent_en: both=%0d wacc=%0d racc=%0d want 1/1/1", both, wacc, racc);
        end
        checks++;
        if (wen !== 3 || wlat !== 4 || wresp !== 2'b00 || wa !== 16'h0300 || d !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL concurrent_wr: en=%0d lat=%0d bresp=%b addr=%h want 3/4/00/0300",
                     wen, wlat, wresp, wa);
        end
        checks++;
        if (ren !== TO + 1 || rlat !== TO + 2 || rresp !== 2'b10 || rd !== 32'h0 || ra !== 16'h0400) begin
            errors++;
            $display("FAIL concurrent_rd: en=%0d lat=%0d rresp=%b rdata=%h want %0d/%0d/10/0",
                     ren, rlat, rresp, rd, TO + 1, TO + 2);
        end
    endtask

    task automatic test_back_to_back();
        int wen, wlat, ren, rlat, ew_en, ew_lat, er_en, er_lat, wack, wwait, rack, rwait;
        logic [1:0] wresp, rresp, ew_resp, er_resp; logic [DW-1:0] wdat, rval, rd, d;
        logic [AW-1:0] waddr, raddr, wa, ra; logic [SW-1:0] wstrb, s; bit wacc, racc, bp, bc;
        for (int i = 0; i < 16; i++) begin
            waddr = AW'($urandom); raddr = AW'($urandom); wdat = $urandom; rval = $urandom;
            wstrb = SW'($urandom_range(1, 15));
            wack = $urandom_range(0, 8); wwait = $urandom_range(0, 4);
            rack = $urandom_range(0, 8); rwait = $urandom_range(0, 4);
            model(wack, wwait, ew_en, ew_lat, ew_resp);
            model(rack, rwait, er_en, er_lat, er_resp);
            fork
                wr_txn(waddr, wdat, wstrb, wack, wwait, 0, wen, wlat, wresp, wa, d, s, wacc, bp, bc);
                rd_txn(raddr, rval, rack, rwait, ren, rlat, rresp, rd, ra, racc);
            join
            checks++;
            if (!wacc || wen !== ew_en || wlat !== ew_lat || wresp !== ew_resp || !bc
                || wa !== {waddr[AW-1:2], 2'b00} || d !== wdat || s !== wstrb) begin
                errors++;
                $display("FAIL b2b_wr_%0d: en=%0d lat=%0d bresp=%b addr=%h data=%h strb=%h want %0d/%0d/%b/%h/%h/%h",
                         i, wen, wlat, wresp, wa, d, s, ew_en, ew_lat, ew_resp,
                         {waddr[AW-1:2], 2'b00}, wdat, wstrb);
            end
            checks++;
            if (!racc || ren !== er_en || rlat !== er_lat || rresp !== er_resp
                || rd !== ((er_resp == 2'b00) ? rval : 32'h0) || ra !== {raddr[AW-1:2], 2'b00}) begin
                errors++;
                $display("FAIL b2b_rd_%0d: en=%0d lat=%0d rresp=%b rdata=%h addr=%h want %0d/%0d/%b",
                         i, ren, rlat, rresp, rd, ra, er_en, er_lat, er_resp);
            end
        end
    endtask

    task automatic test_backpressure();
        int en, lat; logic [1:0] resp; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;
        bit acc, bp, bc;
        wr_txn(16'h0060, 32'h7777_8888, 4'hF, 0, 2, 6, en, lat, resp, a, d, s, acc, bp, bc);
        checks++;
        if (!bp || !bc || resp !== 2'b10 || en !== TO + 2) begin
            errors++;
            $display("FAIL backpressure: stable=%0d clr=%0d bresp=%b en=%0d want 1/1/10/%0d",
                     bp, bc, resp, en, TO + 2);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_b;
        @(posedge clk); #1;
        s_axil_awaddr = 16'h0070; s_axil_wdata = 32'h1234; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        checks++;
        if (reg_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: reg_wr_en=%b want 1", reg_wr_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (reg_wr_en !== 1'b0 || s_axil_bvalid !== 1'b0 || reg_wr_addr !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_async: en=%b bvalid=%b addr=%h want 0/0/0",
                     reg_wr_en, s_axil_bvalid, reg_wr_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0; reg_wr_ack = 1'b1;
        seen_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (s_axil_bvalid !== 1'b0 || reg_wr_en !== 1'b0) seen_b = 1'b1;
        end
        reg_wr_ack = 1'b0;
        checks++;
        if (seen_b) begin
            errors++;
            $display("FAIL rst_mid_after: bvalid/en activity=%0d want 0", seen_b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_aw_without_w();
        test_read_wait();
        test_timeout();
        test_ack_on_expiry();
        test_concurrent();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_single_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
